// File: rtl/apb_regbank_gen.sv
// Parametrised APB slave register bank: CTRL write enables, RO STATUS, NUM_REGS data registers.
// Optional byte strobes via `define APB_PSTRB_EN (adds the pstrb port).
module apb_regbank_gen #(
    parameter int          DATA_W      = 32,
    parameter int          NUM_REGS    = 4,
    parameter int          ADDR_W      = 32,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] RST_BASE    = 32'h5A5A_0000
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_PSTRB_EN
    input  logic [DATA_W/8-1:0] pstrb,
`endif
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int B     = DATA_W / 8;
    localparam int LSB   = $clog2(B);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]          state;
    logic [3:0]          wcnt;
    logic [NUM_REGS-1:0] ctrl_q;
    logic [15:0]         wr_cnt;
    logic                sticky;
    logic [DATA_W-1:0]   data_q [NUM_REGS];

    logic [ADDR_W-1:0]   word_idx;
    logic [IDX_W-1:0]    didx;
    logic                aligned, in_range, is_ctrl, is_status, is_data, acc_err;
    logic [DATA_W-1:0]   status_val, cur_val, wmask, new_val;

    always_comb begin
        word_idx  = paddr >> LSB;
        didx      = IDX_W'(word_idx - ADDR_W'(2));
        aligned   = (paddr[LSB-1:0] == '0);
        in_range  = (word_idx < ADDR_W'(NUM_REGS + 2));
        is_ctrl   = (word_idx == '0);
        is_status = (word_idx == ADDR_W'(1));
        is_data   = in_range && !is_ctrl && !is_status;

        status_val       = '0;
        status_val[15:0] = wr_cnt;
        status_val[16]   = sticky;

        if (is_ctrl)
            cur_val = DATA_W'(ctrl_q);
        else if (is_status)
            cur_val = status_val;
        else
            cur_val = data_q[didx];

`ifdef APB_PSTRB_EN
        wmask = '0;
        for (int unsigned b = 0; b < B; b++)
            wmask[8*b +: 8] = {8{pstrb[b]}};
`else
        wmask = '1;
`endif
        // Unstrobed bytes keep the current register contents
        new_val = (cur_val & ~wmask) | (pwdata & wmask);

        acc_err = !aligned || !in_range
                || (pwrite && is_status)
                || (pwrite && is_data && !ctrl_q[didx]);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= ST_IDLE;
            wcnt    <= '0;
            ctrl_q  <= '0;
            wr_cnt  <= '0;
            sticky  <= 1'b0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++)
                data_q[i] <= DATA_W'(RST_BASE) + DATA_W'(i);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (psel && !penable)
                        state <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (!psel) begin
                        state <= ST_IDLE;
                    end else if (penable) begin
                        state <= ST_ACCESS;
                        wcnt  <= 4'(WAIT_CYCLES);
                    end
                end
                ST_ACCESS: begin
                    if (!psel) begin
                        state <= ST_IDLE;
                    end else if (wcnt != '0) begin
                        wcnt <= wcnt - 4'd1;
                    end else begin
                        if (acc_err) begin
                            sticky  <= 1'b1;
                            pslverr <= 1'b1;
                            if (!pwrite)
                                prdata <= '0;
                        end else if (pwrite) begin
                            if (is_ctrl) begin
                                ctrl_q <= new_val[NUM_REGS-1:0];
                            end else begin
                                data_q[didx] <= new_val;
                                if (wr_cnt != 16'hFFFF)
                                    wr_cnt <= wr_cnt + 16'd1;
                            end
                        end else begin
                            prdata <= cur_val;
                            if (is_status)
                                sticky <= 1'b0;
                        end
                        pready <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                default: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
